g_4arb_rr: RTL and testbench

G_4ARB_RR -- requirements
Module: g_4arb_rr

---
 rtl/g_4arb_rr.sv | 120 ++++++++++++
 tb/tb_g_4arb_rr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/g_4arb_rr.sv
// Four-way round-robin arbiter with registered one-hot grants and an optional
// maximum-tenure timeout. Requester A is active-low at the pin; B..D are active-high.
module g_4arb_rr #(
    parameter int unsigned MAXHOLD = 16
) (
    input  logic CK,
    input  logic CDN,
    input  logic AN,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic GA,
    output logic GB,
    output logic GC,
    output logic GD,
    output logic Y,
    output logic BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic       HOLD_EN   = (MAXHOLD != 32'd0);
    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 32'd1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] req_s;
    logic [3:0] gnt_r;
    logic [3:0] gnt_nxt_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_nxt_s;
    logic [7:0] tcnt_r;
    logic [7:0] tcnt_nxt_s;
    logic [2:0] pick_s;
    logic       owner_req_s;
    logic       timeout_s;

    // Returns {found, index} of the first requester at or above ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + i[1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign req_s       = {D, C, B, ~AN};
    assign pick_s      = rr_pick(req_s, ptr_r);
    assign owner_req_s = |(req_s & gnt_r);
    // The grant has already been high for MAXHOLD cycles when tcnt reaches MAXHOLD-1.
    assign timeout_s   = HOLD_EN && (tcnt_r == HOLD_LAST);

    // Next-state, grant, pointer and tenure decode.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        ptr_nxt_s   = ptr_r;
        tcnt_nxt_s  = tcnt_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = 4'b0001 << pick_s[1:0];
                    ptr_nxt_s   = pick_s[1:0] + 2'd1;
                    tcnt_nxt_s  = 8'd0;
                end else begin
                    gnt_nxt_s   = 4'b0000;
                end
            end
            GRANT: begin
                tcnt_nxt_s = tcnt_r + 8'd1;
                if (!owner_req_s || timeout_s) begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = 4'b0000;
                end else begin
                    gnt_nxt_s   = gnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 4'b0000;
                ptr_nxt_s   = 2'd0;
                tcnt_nxt_s  = 8'd0;
            end
        endcase
    end

    // State, grant, pointer and tenure registers.
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            ptr_r   <= 2'd0;
            tcnt_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            tcnt_r  <= tcnt_nxt_s;
        end
    end

    assign GA   = gnt_r[0];
    assign GB   = gnt_r[1];
    assign GC   = gnt_r[2];
    assign GD   = gnt_r[3];
    assign BUSY = (state_r == GRANT);
    assign Y    = ~AN | B | C | D;

endmodule

// File: tb/tb_g_4arb_rr.sv
// Bench for g_4arb_rr: two instances (MAXHOLD=4 and MAXHOLD=0) share one set of
// request inputs and are compared every cycle against an owner/pointer model.
module tb_g_4arb_rr;

    logic ck  = 1'b0;
    logic cdn = 1'b0;
    logic an  = 1'b1;
    logic b   = 1'b0;
    logic c   = 1'b0;
    logic d   = 1'b0;
    logic ga0, gb0, gc0, gd0, y0, busy0;
    logic ga1, gb1, gc1, gd1, y1, busy1;

    g_4arb_rr #(.MAXHOLD(4)) dut (
        .CK(ck), .CDN(cdn), .AN(an), .B(b), .C(c), .D(d),
        .GA(ga0), .GB(gb0), .GC(gc0), .GD(gd0), .Y(y0), .BUSY(busy0)
    );

    g_4arb_rr #(.MAXHOLD(0)) dut_nt (
        .CK(ck), .CDN(cdn), .AN(an), .B(b), .C(c), .D(d),
        .GA(ga1), .GB(gb1), .GC(gc1), .GD(gd1), .Y(y1), .BUSY(busy1)
    );

    always #5 ck = ~ck;

    int n_chk = 0;
    int n_fail = 0;

    // Model: current owner (-1 none), priority pointer, cycles the grant has been high.
    int owner [2] = '{-1, -1};
    int ptr   [2] = '{0, 0};
    int held  [2] = '{0, 0};
    int wait_c [4] = '{0, 0, 0, 0};
    logic [3:0] r_last = 4'b0000;

    function automatic int mh(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic logic [3:0] req_vec();
        return {d, c, b, ~an};
    endfunction

    function automatic logic [3:0] gnt_of(input int k);
        return (k == 0) ? {gd0, gc0, gb0, ga0} : {gd1, gc1, gb1, ga1};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int  i;
        bit  found;
        if (owner[k] < 0) begin
            found = 1'b0;
            for (int o = 0; o < 4; o++) begin
                i = (ptr[k] + o) % 4;
                if (!found && r[i]) begin
                    found    = 1'b1;
                    owner[k] = i;
                    ptr[k]   = (i + 1) % 4;
                    held[k]  = 1;
                end
            end
        end else if (!r[owner[k]] || (mh(k) > 0 && held[k] >= mh(k))) begin
            owner[k] = -1;
            held[k]  = 0;
        end else begin
            held[k]++;
        end
    endtask

    // Reference model advances on each edge and is cleared by reset at once.
    always @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            for (int k = 0; k < 2; k++) begin
                owner[k] = -1;
                ptr[k]   = 0;
                held[k]  = 0;
            end
            r_last = 4'b0000;
        end else begin
            r_last = req_vec();
            for (int k = 0; k < 2; k++) model_step(k, r_last);
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge ck) begin
        logic [3:0] g;
        for (int k = 0; k < 2; k++) begin
            g = gnt_of(k);
            check("grant", int'(g), (owner[k] < 0) ? 0 : (1 << owner[k]));
            check("busy", int'((k == 0) ? busy0 : busy1), (owner[k] < 0) ? 0 : 1);
        end
        check("y", int'(y0), int'(|req_vec()));
        check("y_nt", int'(y1), int'(|req_vec()));
        // An owner cut off by timeout also sits out its own idle cycle, hence the +2.
        g = gnt_of(0);
        for (int i = 0; i < 4; i++) begin
            if (cdn && r_last[i] && !g[i]) wait_c[i]++;
            else wait_c[i] = 0;
            check("starve", int'(wait_c[i] <= 3 * (mh(0) + 1) + 2), 1);
        end
    end

    task automatic set_req(input logic [3:0] r);
        an = ~r[0];
        b  = r[1];
        c  = r[2];
        d  = r[3];
    endtask

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    task automatic pulse_reset();
        cdn = 1'b0;
        #2;
        cdn = 1'b1;
    endtask

    initial begin
        logic [3:0] rv;
        int exp_g;

        set_req(4'b0000);
        tick();
        tick();
        check("rst_gnt", int'(gnt_of(0)), 0);
        check("rst_busy", int'(busy0), 0);

        // A and B request at reset release: A first, then B after A lets go.
        set_req(4'b0011);
        cdn = 1'b1;
        tick();
        check("a_first", int'(gnt_of(0)), 1);
        check("a_busy", int'(busy0), 1);
        check("a_first_nt", int'(gnt_of(1)), 1);
        set_req(4'b0010);
        tick();
        check("a_release", int'(gnt_of(0)), 0);
        tick();
        check("b_next", int'(gnt_of(0)), 2);
        set_req(4'b0000);
        tick();
        tick();

        // All four requesting: 4 cycles each, one idle cycle between, rotating A..D.
        set_req(4'b1111);
        pulse_reset();
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp_g = (e % 5 == 0) ? 0 : (1 << (((e - 1) / 5) % 4));
            check("rotate", int'(gnt_of(0)), exp_g);
        end
        check("rotate_nt", int'(gnt_of(1)), 1);

        // Without timeout a lone requester keeps its grant through TCNT wrap.
        set_req(4'b0100);
        pulse_reset();
        for (int e = 1; e <= 300; e++) begin
            tick();
            check("hold_c", int'(gnt_of(1)), 4);
        end

        // Reset mid-grant drops GD before any edge; D is re-granted on the first edge.
        set_req(4'b1000);
        pulse_reset();
        tick();
        tick();
        check("gd_pre", int'(gd1), 1);
        cdn = 1'b0;
        #1;
        check("gd_async", int'(gd0), 0);
        check("gd_async_nt", int'(gd1), 0);
        check("busy_async", int'(busy1), 0);
        #1;
        cdn = 1'b1;
        tick();
        check("gd_regrant", int'(gd0), 1);
        check("gd_regrant_nt", int'(gd1), 1);

        // Y follows AN between edges while grants wait for the next edge.
        set_req(4'b0000);
        tick();
        tick();
        tick();
        check("y_idle", int'(y0), 0);
        #4;
        an = 1'b0;
        #1;
        check("y_now", int'(y0), 1);
        check("y_no_gnt", int'(gnt_of(1)), 0);
        tick();
        check("y_gnt", int'(gnt_of(1)), 1);

        // A sub-cycle drop of the owner's request that no edge samples keeps the grant.
        #4;
        an = 1'b1;
        #2;
        an = 1'b0;
        tick();
        check("glitch_hold", int'(gnt_of(1)), 1);

        // Random requests with occasional glitches and asynchronous resets.
        for (int n = 0; n < 10000; n++) begin
            tick();
            rv = req_vec();
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    if ($urandom_range(11, 0) == 0) rv[i] = 1'b0;
                end else begin
                    if ($urandom_range(3, 0) == 0) rv[i] = 1'b1;
                end
            end
            set_req(rv);
            if ($urandom_range(1999, 0) == 0) begin
                pulse_reset();
            end else if ($urandom_range(99, 0) == 0) begin
                #1;
                an = ~an;
                #2;
                an = ~an;
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
